// File: rtl/dca_access_request_gen.sv
// DCA access request generator: turns sweep sequencer issue strobes
// into addressed read requests queued in a small FIFO.
module dca_access_request_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_row_stride,
  input  logic [ADDR_WIDTH-1:0] cfg_col_stride,
  input  logic                  sched_init,
  input  logic                  sched_a_issue,
  input  logic                  sched_b_issue,
  input  logic                  sched_col_next,
  input  logic                  sched_row_next,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_is_b,
  output logic                  busy,
  output logic                  err_overflow,
  output logic                  err_protocol
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] row_stride;
  logic [ADDR_WIDTH-1:0] col_stride;
  logic [ADDR_WIDTH-1:0] row_addr;
  logic [ADDR_WIDTH-1:0] col_addr;
  logic                  col_is_zero;

  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic                  mem_b    [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  last_b;

  logic                  do_init;
  logic                  act;
  logic                  a_req;
  logic                  b_req;
  logic                  b_bad;
  logic                  both_adv;
  logic                  pop;
  logic [CW-1:0]         free;
  logic                  push_a;
  logic                  push_b;
  logic                  drop;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [ADDR_WIDTH-1:0] row_nxt;
  logic [PW-1:0]         wr_ptr1;

  assign do_init  = enable & sched_init;
  assign act      = enable & ~sched_init;
  assign a_req    = act & sched_a_issue;
  assign b_req    = act & sched_b_issue & ~col_is_zero;
  assign b_bad    = act & sched_b_issue & col_is_zero;
  assign both_adv = act & sched_col_next & sched_row_next;

  assign req_valid = (count != '0);
  assign busy      = req_valid;
  assign req_addr  = req_valid ? mem_addr[rd_ptr] : last_addr;
  assign req_is_b  = req_valid ? mem_b[rd_ptr] : last_b;

  assign pop    = req_valid & req_ready;
  assign free   = CW'(DEPTH) - count + CW'(pop);
  assign push_a = a_req & (free != '0);
  assign push_b = b_req & (push_a ? (free > CW'(1)) : (free != '0));
  assign drop   = (a_req & ~push_a) | (b_req & ~push_b);

  assign b_addr  = col_addr - col_stride;
  assign row_nxt = row_addr + row_stride;
  assign wr_ptr1 = wr_ptr + PW'(1);

  // Latched strides and incremental row/column address tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      row_stride  <= '0;
      col_stride  <= '0;
      row_addr    <= '0;
      col_addr    <= '0;
      col_is_zero <= 1'b1;
    end else if (do_init) begin
      row_stride  <= cfg_row_stride;
      col_stride  <= cfg_col_stride;
      row_addr    <= cfg_base_addr;
      col_addr    <= cfg_base_addr;
      col_is_zero <= 1'b1;
    end else if (act && sched_row_next) begin
      row_addr    <= row_nxt;
      col_addr    <= row_nxt;
      col_is_zero <= 1'b1;
    end else if (act && sched_col_next) begin
      col_addr    <= col_addr + col_stride;
      col_is_zero <= 1'b0;
    end
  end

  // Request FIFO storage, pointers and the last-popped head
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_b[i]    <= 1'b0;
      end
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      last_addr <= '0;
      last_b    <= 1'b0;
    end else begin
      if (push_a) begin
        mem_addr[wr_ptr] <= col_addr;
        mem_b[wr_ptr]    <= 1'b0;
      end else if (push_b) begin
        mem_addr[wr_ptr] <= b_addr;
        mem_b[wr_ptr]    <= 1'b1;
      end
      if (push_a && push_b) begin
        mem_addr[wr_ptr1] <= b_addr;
        mem_b[wr_ptr1]    <= 1'b1;
        wr_ptr            <= wr_ptr + PW'(2);
      end else if (push_a || push_b) begin
        wr_ptr <= wr_ptr1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PW'(1);
        last_addr <= mem_addr[rd_ptr];
        last_b    <= mem_b[rd_ptr];
      end
      count <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
    end
  end

  // Sticky error flags, cleared by reset or a new sweep
  always_ff @(posedge clk) begin
    if (rst || do_init) begin
      err_overflow <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      err_overflow <= err_overflow | drop;
      err_protocol <= err_protocol | b_bad | both_adv;
    end
  end

endmodule

// File: tb/tb_dca_access_request_gen.sv
// Bench for dca_access_request_gen: strobe vector table plus
// scoreboard of expected requests checked as the DUT pops them.
module tb_dca_access_request_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] cfg_base_addr;
  logic [31:0] cfg_row_stride;
  logic [31:0] cfg_col_stride;
  logic        sched_init;
  logic        sched_a_issue;
  logic        sched_b_issue;
  logic        sched_col_next;
  logic        sched_row_next;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_is_b;
  logic        busy;
  logic        err_overflow;
  logic        err_protocol;

  dca_access_request_gen #(.ADDR_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .cfg_base_addr(cfg_base_addr),
    .cfg_row_stride(cfg_row_stride),
    .cfg_col_stride(cfg_col_stride),
    .sched_init(sched_init),
    .sched_a_issue(sched_a_issue),
    .sched_b_issue(sched_b_issue),
    .sched_col_next(sched_col_next),
    .sched_row_next(sched_row_next),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_is_b(req_is_b),
    .busy(busy),
    .err_overflow(err_overflow),
    .err_protocol(err_protocol)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        is_b;
  } exp_t;

  typedef struct {
    logic        init;
    logic        a;
    logic        b;
    logic        cn;
    logic        rn;
    logic        pa;
    logic [31:0] ea;
    logic        pb;
    logic [31:0] eb;
    logic        proto;
  } vec_t;

  exp_t        q[$];
  vec_t        tbl[13];
  int          nvec = 0;
  int          nerr = 0;
  logic        stall_q = 1'b0;
  logic [31:0] stall_addr;
  logic        stall_b;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    sched_init     = 1'b0;
    sched_a_issue  = 1'b0;
    sched_b_issue  = 1'b0;
    sched_col_next = 1'b0;
    sched_row_next = 1'b0;
  endtask

  task automatic expect_req(input logic [31:0] a, input logic b);
    exp_t e;
    e.addr = a;
    e.is_b = b;
    q.push_back(e);
  endtask

  task automatic do_init();
    clr();
    sched_init = 1'b1;
    tick();
    sched_init = 1'b0;
  endtask

  task automatic drain(input string nm);
    req_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    tick();
    tick();
    chk({nm, "_left"}, q.size(), 0);
    chk({nm, "_valid"}, req_valid, 1'b0);
  endtask

  // Scoreboard pop and hold-while-stalled check
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && req_valid) begin
        chk("stall_addr", req_addr, stall_addr);
        chk("stall_is_b", req_is_b, stall_b);
      end
      if (req_valid && req_ready) begin
        if (q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL pop_unexpected: got %h expected none", req_addr);
        end else begin
          chk("pop_addr", req_addr, q[0].addr);
          chk("pop_is_b", req_is_b, q[0].is_b);
          void'(q.pop_front());
        end
      end
      stall_q    = req_valid && !req_ready;
      stall_addr = req_addr;
      stall_b    = req_is_b;
    end
  end

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 32'h0,   0, 32'h0,   0};
    tbl[1]  = '{0, 0, 0, 1, 0, 0, 32'h0,   0, 32'h0,   0};
    tbl[2]  = '{0, 0, 0, 1, 0, 0, 32'h0,   0, 32'h0,   0};
    tbl[3]  = '{0, 1, 1, 0, 0, 1, 32'h108, 1, 32'h104, 0};
    tbl[4]  = '{0, 1, 0, 0, 1, 1, 32'h108, 0, 32'h0,   0};
    tbl[5]  = '{0, 1, 0, 0, 0, 1, 32'h140, 0, 32'h0,   0};
    tbl[6]  = '{0, 0, 1, 0, 0, 0, 32'h0,   0, 32'h0,   1};
    tbl[7]  = '{1, 0, 0, 0, 0, 0, 32'h0,   0, 32'h0,   0};
    tbl[8]  = '{0, 0, 0, 1, 0, 0, 32'h0,   0, 32'h0,   0};
    tbl[9]  = '{0, 0, 1, 0, 0, 0, 32'h0,   1, 32'h100, 0};
    tbl[10] = '{0, 0, 0, 1, 1, 0, 32'h0,   0, 32'h0,   1};
    tbl[11] = '{0, 0, 1, 0, 0, 0, 32'h0,   0, 32'h0,   1};
    tbl[12] = '{0, 1, 0, 0, 0, 1, 32'h140, 0, 32'h0,   1};

    rst            = 1'b1;
    enable         = 1'b0;
    req_ready      = 1'b0;
    cfg_base_addr  = 32'h0;
    cfg_row_stride = 32'h0;
    cfg_col_stride = 32'h0;
    clr();
    tick();
    tick();
    chk("rst_valid", req_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", req_addr, 32'h0);
    chk("rst_is_b", req_is_b, 1'b0);
    chk("rst_ovf", err_overflow, 1'b0);
    chk("rst_proto", err_protocol, 1'b0);

    rst            = 1'b0;
    enable         = 1'b1;
    cfg_base_addr  = 32'h100;
    cfg_row_stride = 32'h40;
    cfg_col_stride = 32'h4;
    do_init();

    // single A issue
    req_ready     = 1'b1;
    sched_a_issue = 1'b1;
    expect_req(32'h100, 1'b0);
    tick();
    clr();
    chk("a1_valid", req_valid, 1'b1);
    chk("a1_addr", req_addr, 32'h100);
    chk("a1_is_b", req_is_b, 1'b0);
    tick();
    chk("a1_busy", busy, 1'b0);
    chk("a1_hold", req_addr, 32'h100);

    // table-driven strobe sequence, consumer always ready
    for (int i = 0; i < 13; i++) begin
      sched_init     = tbl[i].init;
      sched_a_issue  = tbl[i].a;
      sched_b_issue  = tbl[i].b;
      sched_col_next = tbl[i].cn;
      sched_row_next = tbl[i].rn;
      if (tbl[i].pa) expect_req(tbl[i].ea, 1'b0);
      if (tbl[i].pb) expect_req(tbl[i].eb, 1'b1);
      tick();
      chk($sformatf("tbl%0d_proto", i), err_protocol, tbl[i].proto);
      chk($sformatf("tbl%0d_ovf", i), err_overflow, 1'b0);
    end
    clr();
    drain("tbl");

    // overflow: B of the final pair is dropped
    req_ready = 1'b0;
    do_init();
    for (int i = 0; i < 3; i++) begin
      sched_a_issue  = 1'b1;
      sched_col_next = 1'b1;
      expect_req(32'h100 + 32'(4 * i), 1'b0);
      tick();
    end
    clr();
    chk("ovf_pre", err_overflow, 1'b0);
    sched_a_issue = 1'b1;
    sched_b_issue = 1'b1;
    expect_req(32'h10c, 1'b0);
    tick();
    clr();
    chk("ovf_flag", err_overflow, 1'b1);
    chk("ovf_proto", err_protocol, 1'b0);
    chk("ovf_head", req_addr, 32'h100);
    drain("ovf");
    chk("ovf_sticky", err_overflow, 1'b1);

    // backpressure toggling during six issues
    do_init();
    for (int i = 0; i < 6; i++) begin
      req_ready      = (i % 2) == 1;
      sched_a_issue  = 1'b1;
      sched_col_next = 1'b1;
      expect_req(32'h100 + 32'(4 * i), 1'b0);
      tick();
    end
    clr();
    for (int i = 0; i < 6; i++) begin
      req_ready = (i % 2) == 1;
      tick();
    end
    drain("bp");
    chk("bp_ovf", err_overflow, 1'b0);

    // reset mid-drain
    req_ready = 1'b0;
    do_init();
    for (int i = 0; i < 3; i++) begin
      sched_a_issue  = 1'b1;
      sched_col_next = 1'b1;
      sched_row_next = (i == 2);
      expect_req(32'h100 + 32'(4 * i), 1'b0);
      tick();
    end
    clr();
    chk("mid_proto", err_protocol, 1'b1);
    chk("mid_valid", req_valid, 1'b1);
    req_ready = 1'b1;
    rst       = 1'b1;
    q.delete();
    tick();
    chk("mid_rst_valid", req_valid, 1'b0);
    chk("mid_rst_addr", req_addr, 32'h0);
    chk("mid_rst_proto", err_protocol, 1'b0);
    chk("mid_rst_ovf", err_overflow, 1'b0);
    rst = 1'b0;
    tick();

    // enable low: init and issues are ignored
    enable        = 1'b0;
    sched_init    = 1'b1;
    sched_a_issue = 1'b1;
    tick();
    clr();
    sched_a_issue = 1'b1;
    sched_b_issue = 1'b1;
    tick();
    clr();
    tick();
    chk("en0_valid", req_valid, 1'b0);
    chk("en0_proto", err_protocol, 1'b0);
    enable        = 1'b1;
    sched_a_issue = 1'b1;
    expect_req(32'h0, 1'b0);
    tick();
    clr();
    drain("en1");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
